// File: rtl/encoder_emulator.sv
// Quadrature A/B generator: emits a commanded number of idle-high detents in
// either direction, with per-edge dwell and an inter-detent idle gap.
`timescale 1ns/1ps
module encoder_emulator #(
    parameter int QUARTER_TICKS = 250,
    parameter int GAP_TICKS     = 500,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start_i,
    input  logic [COUNT_WIDTH-1:0] Steps_i,
    input  logic                   Direction_i,
    input  logic                   Abort_i,
    output logic                   EncoderA_o,
    output logic                   EncoderB_o,
    output logic                   Busy_o,
    output logic                   Done_o,
    output logic [COUNT_WIDTH-1:0] Remaining_o
);

    localparam int MAX_TICKS = (QUARTER_TICKS > GAP_TICKS) ? QUARTER_TICKS : GAP_TICKS;
    localparam int TICK_W    = $clog2(MAX_TICKS + 1);
    localparam logic [TICK_W-1:0] QUARTER_LOAD = TICK_W'(QUARTER_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LOAD     = TICK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {IDLE, PHASE, DWELL, GAP} state_t;

    state_t            state;
    logic [1:0]        quarter;
    logic [TICK_W-1:0] ticks;
    logic              dir;
    logic              abort_pending;
    logic              abort_now;
    logic              tick_done;

    // {A,B} levels after quarter edge q; decrement is increment with A and B swapped.
    function automatic logic [1:0] edge_level(input logic [1:0] q, input logic inc);
        logic [1:0] ab;
        case (q)
            2'd0:    ab = 2'b01;
            2'd1:    ab = 2'b00;
            2'd2:    ab = 2'b10;
            default: ab = 2'b11;
        endcase
        edge_level = inc ? ab : {ab[0], ab[1]};
    endfunction

    assign abort_now = abort_pending | Abort_i;
    assign tick_done = (ticks == '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            quarter       <= 2'd0;
            ticks         <= '0;
            dir           <= 1'b1;
            abort_pending <= 1'b0;
            EncoderA_o    <= 1'b1;
            EncoderB_o    <= 1'b1;
            Busy_o        <= 1'b0;
            Done_o        <= 1'b0;
            Remaining_o   <= '0;
        end else begin
            Done_o <= 1'b0;
            case (state)
                IDLE: begin
                    abort_pending <= 1'b0;
                    if (Start_i) begin
                        if (Steps_i != '0) begin
                            Remaining_o              <= Steps_i;
                            dir                      <= Direction_i;
                            Busy_o                   <= 1'b1;
                            {EncoderA_o, EncoderB_o} <= edge_level(2'd0, Direction_i);
                            quarter                  <= 2'd1;
                            ticks                    <= QUARTER_LOAD;
                            state                    <= PHASE;
                        end else begin
                            Done_o <= 1'b1;
                        end
                    end
                end

                PHASE: begin
                    if (Abort_i)
                        abort_pending <= 1'b1;
                    if (!tick_done) begin
                        ticks <= ticks - 1'b1;
                    end else begin
                        {EncoderA_o, EncoderB_o} <= edge_level(quarter, dir);
                        ticks                    <= QUARTER_LOAD;
                        if (quarter == 2'd3) begin
                            // Closing edge of the detent: an abort truncates the run here.
                            quarter     <= 2'd0;
                            Remaining_o <= abort_now ? '0 : Remaining_o - 1'b1;
                            state       <= DWELL;
                        end else begin
                            quarter <= quarter + 2'd1;
                        end
                    end
                end

                DWELL, GAP: begin
                    if (Abort_i)
                        abort_pending <= 1'b1;
                    if (!tick_done) begin
                        ticks <= ticks - 1'b1;
                    end else if (state == DWELL && GAP_TICKS > 0) begin
                        ticks <= GAP_LOAD;
                        state <= GAP;
                    end else if (Remaining_o != '0 && !abort_now) begin
                        {EncoderA_o, EncoderB_o} <= edge_level(2'd0, dir);
                        quarter                  <= 2'd1;
                        ticks                    <= QUARTER_LOAD;
                        state                    <= PHASE;
                    end else begin
                        Busy_o        <= 1'b0;
                        Done_o        <= 1'b1;
                        Remaining_o   <= '0;
                        abort_pending <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_emulator.sv
// Bench for encoder_emulator: arithmetic timing model compared every cycle,
// hand-computed literal points, and a quadrature decoder for net detent count.
`timescale 1ns/1ps
module tb_encoder_emulator;

    localparam int Q = 4;
    localparam int G = 8;
    localparam int P = 4 * Q + G;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] steps = 8'd0;
    logic       dir   = 1'b1;
    logic       abort = 1'b0;
    logic       enc_a, enc_b, busy, done;
    logic [7:0] rem;

    int checks = 0;
    int errors = 0;

    encoder_emulator #(.QUARTER_TICKS(Q), .GAP_TICKS(G), .COUNT_WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .Start_i(start), .Steps_i(steps),
        .Direction_i(dir), .Abort_i(abort), .EncoderA_o(enc_a), .EncoderB_o(enc_b),
        .Busy_o(busy), .Done_o(done), .Remaining_o(rem)
    );

    always #5 Clock = ~Clock;

    // ---------------- behavioural model: outputs as a function of time since acceptance
    int   tcount = 0;
    int   k = 0, nfull = 0, neff = 0, zdone = -1;
    bit   job_active = 0, mdir = 1;
    logic [1:0] exp_ab = 2'b11;
    logic exp_busy = 0, exp_done = 0;
    int   exp_rem = 0;

    // Position along the Gray cycle 11 -> 01 -> 00 -> 10 (increment, {A,B}).
    function automatic logic [1:0] gray_ab(input int pos, input bit inc);
        logic [1:0] v;
        case (pos % 4)
            0:       v = 2'b11;
            1:       v = 2'b01;
            2:       v = 2'b00;
            default: v = 2'b10;
        endcase
        return inc ? v : {v[0], v[1]};
    endfunction

    always @(posedge Clock) begin
        int t, d, n, r;
        bit busy_now;
        tcount++;
        t = tcount;
        if (!Reset) begin
            job_active = 0;
            zdone      = -1;
        end else begin
            busy_now = job_active && (t <= k + neff * P);
            if (busy_now && abort && t > k) begin
                d = t - k; n = d / P; r = d % P;
                if (n < neff && r <= 3 * Q) neff = n + 1;
            end
            if (!busy_now && start) begin
                if (steps != 0) begin
                    job_active = 1; k = t; nfull = steps; neff = steps; mdir = dir;
                end else begin
                    zdone = t;
                end
            end
        end
        exp_ab = 2'b11; exp_busy = 0; exp_done = (t == zdone); exp_rem = 0;
        if (job_active) begin
            d = t - k; n = d / P; r = d % P;
            if (d < neff * P) begin
                exp_busy = 1;
                exp_ab   = gray_ab((r < 3 * Q) ? r / Q + 1 : 0, mdir);
                if (r < 3 * Q)           exp_rem = nfull - n;
                else if (n == neff - 1)  exp_rem = 0;
                else                     exp_rem = nfull - n - 1;
            end else if (d == neff * P) begin
                exp_done = 1;
            end
        end
    end

    // ---------------- per-cycle comparison against the model
    always @(negedge Clock) begin
        logic [1:0] w_ab;
        logic w_busy, w_done;
        int w_rem;
        if (!Reset) begin
            w_ab = 2'b11; w_busy = 0; w_done = 0; w_rem = 0;
        end else begin
            w_ab = exp_ab; w_busy = exp_busy; w_done = exp_done; w_rem = exp_rem;
        end
        checks++;
        if ({enc_a, enc_b} !== w_ab || busy !== w_busy || done !== w_done || int'(rem) != w_rem) begin
            errors++;
            $display("FAIL model edge %0d: got AB=%b busy=%b done=%b rem=%0d want AB=%b busy=%b done=%b rem=%0d",
                     tcount, {enc_a, enc_b}, busy, done, rem, w_ab, w_busy, w_done, w_rem);
        end
    end

    // ---------------- quadrature decoder: signed quarter-step count
    int qcount = 0;
    logic [1:0] prev_ab = 2'b11;

    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(negedge Clock) begin
        int delta;
        delta = (pos_of({enc_a, enc_b}) - pos_of(prev_ab) + 4) % 4;
        if (delta == 1) qcount++;
        else if (delta == 3) qcount--;
        prev_ab = {enc_a, enc_b};
    end

    // ---------------- helpers
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_edge(input int e);
        while (tcount < e) @(negedge Clock);
        #1;
    endtask

    task automatic check_now(input string name, input int a, input int b, input int bu, input int dn, input int rm);
        check({name, ".A"}, int'(enc_a), a);
        check({name, ".B"}, int'(enc_b), b);
        check({name, ".busy"}, int'(busy), bu);
        check({name, ".done"}, int'(done), dn);
        check({name, ".rem"}, int'(rem), rm);
    endtask

    task automatic chk_at(input int e, input string name, input int a, input int b, input int bu, input int dn, input int rm);
        wait_edge(e);
        check_now(name, a, b, bu, dn, rm);
    endtask

    task automatic pulse_start(input int e, input int n, input bit d);
        wait_edge(e - 1);
        start = 1'b1; steps = 8'(n); dir = d;
        wait_edge(e);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int qbase;
        #1 Reset = 1'b0;
        wait_edge(2);
        check_now("reset", 1, 1, 0, 0, 0);
        Reset = 1'b1;
        qbase = qcount;

        // Increment, 3 detents accepted at edge 10; Starts at 15 and 82 ignored.
        pulse_start(10, 3, 1'b1);
        check_now("inc.e10", 0, 1, 1, 0, 3);
        chk_at(14, "inc.e14", 0, 0, 1, 0, 3);
        pulse_start(15, 7, 1'b0);
        chk_at(18, "inc.e18", 1, 0, 1, 0, 3);
        chk_at(21, "inc.e21", 1, 0, 1, 0, 3);
        chk_at(22, "inc.e22", 1, 1, 1, 0, 2);
        chk_at(46, "inc.e46", 1, 1, 1, 0, 1);
        chk_at(70, "inc.e70", 1, 1, 1, 0, 0);
        chk_at(81, "inc.e81", 1, 1, 1, 0, 0);
        pulse_start(82, 5, 1'b1);
        check_now("inc.e82", 1, 1, 0, 1, 0);
        check("inc.net_quarters", qcount - qbase, 12);

        // Decrement, 2 detents accepted at edge 83 (one after completion).
        qbase = qcount;
        pulse_start(83, 2, 1'b0);
        check_now("dec.e83", 1, 0, 1, 0, 2);
        chk_at(87, "dec.e87", 0, 0, 1, 0, 2);
        chk_at(91, "dec.e91", 0, 1, 1, 0, 2);
        chk_at(95, "dec.e95", 1, 1, 1, 0, 1);
        chk_at(107, "dec.e107", 1, 0, 1, 0, 1);
        chk_at(131, "dec.e131", 1, 1, 0, 1, 0);
        check("dec.net_detents", (qcount - qbase) / 4, -2);

        // Zero-step command: done only.
        pulse_start(140, 0, 1'b1);
        check_now("zero.e140", 1, 1, 0, 1, 0);
        chk_at(141, "zero.e141", 1, 1, 0, 0, 0);

        // Abort in detent 1 of a 5-detent run.
        pulse_start(150, 5, 1'b1);
        wait_edge(179);
        abort = 1'b1;
        wait_edge(180);
        abort = 1'b0;
        chk_at(185, "abort.e185", 1, 0, 1, 0, 4);
        chk_at(186, "abort.e186", 1, 1, 1, 0, 0);
        chk_at(197, "abort.e197", 1, 1, 1, 0, 0);
        chk_at(198, "abort.e198", 1, 1, 0, 1, 0);
        chk_at(210, "abort.e210", 1, 1, 0, 0, 0);

        // Asynchronous reset mid-detent.
        pulse_start(220, 3, 1'b1);
        chk_at(230, "rst.e230", 1, 0, 1, 0, 3);
        Reset = 1'b0;
        #1;
        check_now("rst.async", 1, 1, 0, 0, 0);
        wait_edge(233);
        Reset = 1'b1;
        chk_at(236, "rst.e236", 1, 1, 0, 0, 0);
        wait_edge(260);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
